// File: rtl/AluCtrlSig_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU op codes,
// opcode/funct values, datapath mux selects and the controller state type.
package AluCtrlSig_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_XOR = 4'd3,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } AluOp_t;

    // Opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes, instr[5:0]
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    // ALU B-operand select
    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } ctrl_state_t;

endpackage

// File: rtl/alu_funct_decoder.sv
// R-type funct field to ALU operation; flags funct codes the ALU does not support.
module alu_funct_decoder
    import AluCtrlSig_pkg::*;
(
    input  logic [5:0] funct,
    output AluOp_t     alu_op,
    output logic       valid
);

    // Map funct to ALU op; unsupported codes fall back to ADD with valid low
    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (funct)
            F_ADD:   alu_op = ALU_ADD;
            F_SUB:   alu_op = ALU_SUB;
            F_AND:   alu_op = ALU_AND;
            F_OR:    alu_op = ALU_OR;
            F_NOR:   alu_op = ALU_NOR;
            F_XOR:   alu_op = ALU_XOR;
            F_SLT:   alu_op = ALU_SLT;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: state register plus combinational decode of
// datapath strobes, mux selects and ALU control, with memory-ready waits.
module mips_multicycle_ctrl
    import AluCtrlSig_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 0
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_write,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [3:0] alu_ctrl,
    output logic [3:0] state_o,
    output logic       illegal_op,
    output logic       mem_timeout
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    // Instruction class captured in DECODE so later states never re-read opcode
    logic        is_sw_q;
    logic        is_bne_q;
    logic [31:0] wait_cnt;

    AluOp_t      funct_op;
    logic        funct_valid;
    AluOp_t      alu_op;
    logic        pc_en_d;
    logic        ir_write_d;
    logic        mem_write_d;
    logic        reg_write_d;
    logic        illegal_d;

    alu_funct_decoder u_funct_dec (
        .funct  (funct),
        .alu_op (funct_op),
        .valid  (funct_valid)
    );

    // Per-state output decode and next-state selection
    always_comb begin
        state_next  = S_FETCH;
        pc_en_d     = 1'b0;
        ir_write_d  = 1'b0;
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        illegal_d   = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRC_B_REG;
        pc_src      = PC_SRC_ALU;
        alu_op      = ALU_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRC_B_FOUR;
                ir_write_d = mem_ready;
                pc_en_d    = mem_ready;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW:   state_next = S_MEMADR;
                    OP_RTYPE:       state_next = S_EXECUTE;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_ADDI:        state_next = S_ADDIEX;
                    OP_J:           state_next = S_JUMP;
                    default: begin
                        illegal_d  = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                state_next = is_sw_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_d = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                mem_write_d = 1'b1;
                state_next  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = funct_op;
                illegal_d  = ~funct_valid;
                state_next = funct_valid ? S_ALUWB : S_FETCH;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_d = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_en_d   = is_bne_q ? ~zero : zero;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_d = 1'b1;
            end
            S_JUMP: begin
                pc_src  = PC_SRC_JUMP;
                pc_en_d = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Strobes are forced low for the whole reset cycle so an aborted
    // instruction cannot write before the reset edge lands
    assign pc_en      = ~reset & pc_en_d;
    assign ir_write   = ~reset & ir_write_d;
    assign mem_write  = ~reset & mem_write_d;
    assign reg_write  = ~reset & reg_write_d;
    assign illegal_op = ~reset & illegal_d;
    assign alu_ctrl   = alu_op;
    assign state_o    = state;

    // State register, DECODE-time instruction flags and FETCH wait timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            is_sw_q     <= 1'b0;
            is_bne_q    <= 1'b0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                is_sw_q  <= (opcode == OP_SW);
                is_bne_q <= (opcode == OP_BNE);
            end
            if (FETCH_TIMEOUT != 0 && state == S_FETCH && !mem_ready) begin
                if (wait_cnt != FETCH_TIMEOUT)
                    wait_cnt <= wait_cnt + 32'd1;
                // Flag rises on the same edge the count reaches the limit
                if (wait_cnt + 32'd1 == FETCH_TIMEOUT)
                    mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle vector table fed
// through a scoreboard queue, plus a FETCH timeout sequence.
module tb_mips_multicycle_ctrl;
    import AluCtrlSig_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_ctrl, state_o;
    logic       illegal_op, mem_timeout;

    logic       t_pc_en, t_ir_write, t_mem_write, t_iord, t_reg_write, t_reg_dst, t_mem_to_reg, t_alu_src_a;
    logic [1:0] t_alu_src_b, t_pc_src;
    logic [3:0] t_alu_ctrl, t_state_o;
    logic       t_illegal_op, t_mem_timeout;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_ctrl(alu_ctrl), .state_o(state_o), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout)
    );

    mips_multicycle_ctrl #(.FETCH_TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(t_pc_en), .ir_write(t_ir_write), .mem_write(t_mem_write), .iord(t_iord),
        .reg_write(t_reg_write), .reg_dst(t_reg_dst), .mem_to_reg(t_mem_to_reg),
        .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b), .pc_src(t_pc_src), .alu_ctrl(t_alu_ctrl),
        .state_o(t_state_o), .illegal_op(t_illegal_op), .mem_timeout(t_mem_timeout)
    );

    // {state, pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg, src_a, src_b, pc_src, alu, illegal}
    logic [20:0] act, act_to;
    assign act    = {state_o, pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg,
                     alu_src_a, alu_src_b, pc_src, alu_ctrl, illegal_op};
    assign act_to = {t_state_o, t_pc_en, t_ir_write, t_mem_write, t_iord, t_reg_write, t_reg_dst,
                     t_mem_to_reg, t_alu_src_a, t_alu_src_b, t_pc_src, t_alu_ctrl, t_illegal_op};

    localparam logic [20:0] FULL_MASK   = '1;
    localparam logic [20:0] STROBE_MASK = (21'd1 << 16) | (21'd1 << 15) | (21'd1 << 14) | (21'd1 << 12) | 21'd1;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic        rst;
        logic [20:0] exp;
        logic [20:0] mask;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [20:0] mk(input ctrl_state_t st, input logic pe, input logic irw,
                                       input logic mw, input logic io, input logic rw, input logic rd,
                                       input logic m2r, input logic sa, input logic [1:0] sbs,
                                       input logic [1:0] ps, input logic [3:0] alu, input logic ill);
        return {st, pe, irw, mw, io, rw, rd, m2r, sa, sbs, ps, alu, ill};
    endfunction

    // Hand-derived expected output words per controller state
    function automatic logic [20:0] e_fetch(input logic rdy);
        return mk(S_FETCH, rdy, rdy, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'd2, 0);
    endfunction
    function automatic logic [20:0] e_decode(input logic ill);
        return mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 4'd2, ill);
    endfunction
    function automatic logic [20:0] e_exec(input logic [3:0] alu, input logic ill);
        return mk(S_EXECUTE, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, alu, ill);
    endfunction
    function automatic logic [20:0] e_branch(input logic pe);
        return mk(S_BRANCH, pe, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 4'd6, 0);
    endfunction
    localparam logic [20:0] E_ALUWB  = {S_ALUWB,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'd2, 1'b0};
    localparam logic [20:0] E_MEMADR = {S_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 4'd2, 1'b0};
    localparam logic [20:0] E_MEMRD  = {S_MEMRD,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd2, 1'b0};
    localparam logic [20:0] E_MEMWB  = {S_MEMWB,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'd2, 1'b0};
    localparam logic [20:0] E_MEMWR  = {S_MEMWR,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd2, 1'b0};
    localparam logic [20:0] E_ADDIEX = {S_ADDIEX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 4'd2, 1'b0};
    localparam logic [20:0] E_ADDIWB = {S_ADDIWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd2, 1'b0};
    localparam logic [20:0] E_JUMP   = {S_JUMP,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 4'd2, 1'b0};

    task automatic add_v(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input logic rdy, input logic rst, input logic [20:0] e, input logic [20:0] m);
        vec_t v;
        v.name = nm; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.rst = rst; v.exp = e; v.mask = m;
        tbl.push_back(v);
    endtask

    task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rdy, input logic [20:0] e);
        add_v(nm, op, fn, z, rdy, 1'b0, e, FULL_MASK);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Pop the record for this cycle and compare both instances against it
    task automatic pop_and_check(input int idx);
        vec_t v;
        v = sb.pop_front();
        check($sformatf("row%0d_%s", idx, v.name), 32'(act & v.mask), 32'(v.exp & v.mask));
        check($sformatf("row%0d_%s_to", idx, v.name), 32'(act_to & v.mask), 32'(v.exp & v.mask));
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            reset = tbl[i].rst; opcode = tbl[i].op; funct = tbl[i].fn;
            zero = tbl[i].z; mem_ready = tbl[i].rdy;
            sb.push_back(tbl[i]);
            @(negedge clk);
            pop_and_check(i);
        end
    endtask

    logic [5:0] rt_fn  [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b100110, 6'b101010};
    logic [3:0] rt_alu [7] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd3, 4'd7};

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;

        // Reset held 3 cycles with memory ready: strobes and illegal_op low
        for (int i = 0; i < 3; i++) add_v("reset", 6'b0, 6'b0, 0, 1, 1, '0, STROBE_MASK);

        // R-type, every supported funct: FETCH, DECODE, EXECUTE, ALUWB
        for (int i = 0; i < 7; i++) begin
            add("r_fetch", 6'b000000, rt_fn[i], 0, 1, e_fetch(1));
            add("r_decode", 6'b000000, rt_fn[i], 0, 1, e_decode(0));
            add("r_exec", 6'b000000, rt_fn[i], 0, 1, e_exec(rt_alu[i], 0));
            add("r_aluwb", 6'b000000, rt_fn[i], 0, 1, E_ALUWB);
        end

        // LW, memory not ready for 2 MEMRD cycles; opcode changed after DECODE must not matter
        add("lw_fetch", 6'b100011, 6'b0, 0, 1, e_fetch(1));
        add("lw_decode", 6'b100011, 6'b0, 0, 1, e_decode(0));
        add("lw_memadr", 6'b101011, 6'b0, 0, 1, E_MEMADR);
        add("lw_memrd0", 6'b101011, 6'b0, 0, 0, E_MEMRD);
        add("lw_memrd1", 6'b101011, 6'b0, 0, 0, E_MEMRD);
        add("lw_memrd2", 6'b101011, 6'b0, 0, 1, E_MEMRD);
        add("lw_memwb", 6'b101011, 6'b0, 0, 1, E_MEMWB);

        // SW with one wait cycle in MEMWR
        add("sw_fetch", 6'b101011, 6'b0, 0, 1, e_fetch(1));
        add("sw_decode", 6'b101011, 6'b0, 0, 1, e_decode(0));
        add("sw_memadr", 6'b101011, 6'b0, 0, 1, E_MEMADR);
        add("sw_memwr0", 6'b101011, 6'b0, 0, 0, E_MEMWR);
        add("sw_memwr1", 6'b101011, 6'b0, 0, 1, E_MEMWR);

        // BEQ / BNE with both zero values; BNE row with opcode switched in BRANCH
        add("beq1_fetch", 6'b000100, 6'b0, 1, 1, e_fetch(1));
        add("beq1_decode", 6'b000100, 6'b0, 1, 1, e_decode(0));
        add("beq1_branch", 6'b000100, 6'b0, 1, 1, e_branch(1));
        add("beq0_fetch", 6'b000100, 6'b0, 0, 1, e_fetch(1));
        add("beq0_decode", 6'b000100, 6'b0, 0, 1, e_decode(0));
        add("beq0_branch", 6'b000100, 6'b0, 0, 1, e_branch(0));
        add("bne1_fetch", 6'b000101, 6'b0, 1, 1, e_fetch(1));
        add("bne1_decode", 6'b000101, 6'b0, 1, 1, e_decode(0));
        add("bne1_branch", 6'b000100, 6'b0, 1, 1, e_branch(0));
        add("bne0_fetch", 6'b000101, 6'b0, 0, 1, e_fetch(1));
        add("bne0_decode", 6'b000101, 6'b0, 0, 1, e_decode(0));
        add("bne0_branch", 6'b000101, 6'b0, 0, 1, e_branch(1));

        // ADDI
        add("addi_fetch", 6'b001000, 6'b0, 0, 1, e_fetch(1));
        add("addi_decode", 6'b001000, 6'b0, 0, 1, e_decode(0));
        add("addi_ex", 6'b001000, 6'b0, 0, 1, E_ADDIEX);
        add("addi_wb", 6'b001000, 6'b0, 0, 1, E_ADDIWB);

        // J after one FETCH wait cycle
        add("j_fetchwait", 6'b000010, 6'b0, 0, 0, e_fetch(0));
        add("j_fetch", 6'b000010, 6'b0, 0, 1, e_fetch(1));
        add("j_decode", 6'b000010, 6'b0, 0, 1, e_decode(0));
        add("j_jump", 6'b000010, 6'b0, 0, 1, E_JUMP);

        // Illegal opcode then illegal funct
        add("illop_fetch", 6'b111111, 6'b0, 0, 1, e_fetch(1));
        add("illop_decode", 6'b111111, 6'b0, 0, 1, e_decode(1));
        add("illfn_fetch", 6'b000000, 6'b001000, 0, 1, e_fetch(1));
        add("illfn_decode", 6'b000000, 6'b001000, 0, 1, e_decode(0));
        add("illfn_exec", 6'b000000, 6'b001000, 0, 1, e_exec(4'd2, 1));

        // Reset while SW waits in MEMWR: no write during reset, FETCH afterwards
        add("rst_sw_fetch", 6'b101011, 6'b0, 0, 1, e_fetch(1));
        add("rst_sw_decode", 6'b101011, 6'b0, 0, 1, e_decode(0));
        add("rst_sw_memadr", 6'b101011, 6'b0, 0, 1, E_MEMADR);
        add("rst_sw_memwr", 6'b101011, 6'b0, 0, 0, E_MEMWR);
        add_v("rst_sw_reset", 6'b101011, 6'b0, 0, 0, 1, '0, STROBE_MASK);
        add("rst_sw_fetch0", 6'b101011, 6'b0, 0, 0, e_fetch(0));
        add("rst_sw_fetch1", 6'b101011, 6'b0, 0, 1, e_fetch(1));

        run_table();

        // Neither instance has timed out so far
        check("no_timeout_dflt", 32'(mem_timeout), 32'd0);
        check("no_timeout_to", 32'(t_mem_timeout), 32'd0);

        // FETCH timeout with limit 4: six wait cycles after a fresh reset
        @(posedge clk); #1;
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'b000000; funct = 6'b100000;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check($sformatf("timeout_wait%0d", k), 32'(t_mem_timeout), (k >= 5) ? 32'd1 : 32'd0);
            check($sformatf("timeout_state%0d", k), 32'(t_state_o), 32'(S_FETCH));
            check($sformatf("timeout_dflt%0d", k), 32'(mem_timeout), 32'd0);
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("timeout_irw", 32'(t_ir_write), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("timeout_sticky", 32'(t_mem_timeout), 32'd1);
        check("timeout_sticky_state", 32'(t_state_o), 32'(S_DECODE));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("timeout_cleared", 32'(t_mem_timeout), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
